// File: rtl/mor1kx_branch_resolver_if.sv
// Bundle of the decode push, execute resolve, fetch redirect and counter signals of the
// branch resolver. Signal suffixes are from the resolver's point of view.
interface mor1kx_branch_resolver_if #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned CNT_WIDTH            = 32
);
    logic                            pred_valid_i;
    logic                            pred_ready_o;
    logic                            pred_bf_i;
    logic                            pred_flag_i;
    logic [OPTION_OPERAND_WIDTH-1:0] pred_target_i;
    logic [OPTION_OPERAND_WIDTH-1:0] pred_fallthrough_i;
    logic                            resolve_valid_i;
    logic                            flag_i;
    logic                            flush_i;
    logic                            branch_mispredict_o;
    logic                            redirect_valid_o;
    logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o;
    logic                            redirect_ready_i;
    logic                            cnt_clear_i;
    logic [CNT_WIDTH-1:0]            branch_count_o;
    logic [CNT_WIDTH-1:0]            mispredict_count_o;

    // Pipeline side: decode, execute/ctrl and fetch.
    modport master (
        input  pred_ready_o, branch_mispredict_o, redirect_valid_o, redirect_pc_o,
               branch_count_o, mispredict_count_o,
        output pred_valid_i, pred_bf_i, pred_flag_i, pred_target_i, pred_fallthrough_i,
               resolve_valid_i, flag_i, flush_i, redirect_ready_i, cnt_clear_i
    );

    // Resolver side.
    modport slave (
        input  pred_valid_i, pred_bf_i, pred_flag_i, pred_target_i, pred_fallthrough_i,
               resolve_valid_i, flag_i, flush_i, redirect_ready_i, cnt_clear_i,
        output pred_ready_o, branch_mispredict_o, redirect_valid_o, redirect_pc_o,
               branch_count_o, mispredict_count_o
    );
endinterface

// File: rtl/mor1kx_branch_resolver.sv
// Queues predicted conditional branches, checks each against the real flag at resolve time,
// and on a mispredict squashes the wrong path and holds a redirect PC until fetch takes it.
module mor1kx_branch_resolver #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned PRED_DEPTH           = 2,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input logic                     clk,
    input logic                     rst_n,
    mor1kx_branch_resolver_if.slave bus
);

    localparam int unsigned PtrW = $clog2(PRED_DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    typedef logic [OPTION_OPERAND_WIDTH-1:0] pc_t;
    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    state_e               state_q, state_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]      occ_q, occ_d;
    logic [PRED_DEPTH-1:0] bf_q;
    logic [PRED_DEPTH-1:0] flag_q;
    pc_t                  target_q [PRED_DEPTH];
    pc_t                  fallthrough_q [PRED_DEPTH];
    logic                 mispredict_q, mispredict_d;
    logic                 redirect_valid_q, redirect_valid_d;
    pc_t                  redirect_pc_q, redirect_pc_d;
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    logic full, empty, pred_ready, push, pop, mispredict, taken;
    pc_t  resolved_pc;

    assign full        = occ_q == OccW'(PRED_DEPTH);
    assign empty       = occ_q == '0;
    assign pred_ready  = !full && (state_q == StIdle);
    assign push        = bus.pred_valid_i && pred_ready;
    assign pop         = bus.resolve_valid_i && !empty && (state_q == StIdle);
    assign taken       = bf_q[rd_ptr_q] ? bus.flag_i : !bus.flag_i;
    assign mispredict  = pop && (bus.flag_i != flag_q[rd_ptr_q]);
    assign resolved_pc = taken ? target_q[rd_ptr_q] : fallthrough_q[rd_ptr_q];

    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        occ_d            = occ_q;
        mispredict_d     = 1'b0;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;

        case (state_q)
            StIdle: begin
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
                occ_d = occ_q + OccW'(push) - OccW'(pop);
                // Everything younger than a mispredicted branch, including a same-cycle push,
                // is wrong-path.
                if (mispredict) begin
                    wr_ptr_d         = '0;
                    rd_ptr_d         = '0;
                    occ_d            = '0;
                    mispredict_d     = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = resolved_pc;
                    state_d          = StRedirect;
                end
            end
            StRedirect: begin
                if (bus.redirect_ready_i) begin
                    redirect_valid_d = 1'b0;
                    state_d          = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.flush_i) begin
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            occ_d            = '0;
            mispredict_d     = 1'b0;
            redirect_valid_d = 1'b0;
            state_d          = StIdle;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (pop && !bus.flush_i && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (mispredict && !bus.flush_i && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
        if (bus.cnt_clear_i) begin
            branch_cnt_d  = '0;
            mispred_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            mispredict_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            occ_q            <= occ_d;
            mispredict_q     <= mispredict_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    // Entry storage; a write on a squashed push is harmless since the pointers are reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bf_q   <= '0;
            flag_q <= '0;
            for (int i = 0; i < PRED_DEPTH; i++) begin
                target_q[i]      <= '0;
                fallthrough_q[i] <= '0;
            end
        end else if (push) begin
            bf_q[wr_ptr_q]          <= bus.pred_bf_i;
            flag_q[wr_ptr_q]        <= bus.pred_flag_i;
            target_q[wr_ptr_q]      <= bus.pred_target_i;
            fallthrough_q[wr_ptr_q] <= bus.pred_fallthrough_i;
        end
    end

    assign bus.pred_ready_o        = pred_ready;
    assign bus.branch_mispredict_o = mispredict_q;
    assign bus.redirect_valid_o    = redirect_valid_q;
    assign bus.redirect_pc_o       = redirect_pc_q;
    assign bus.branch_count_o      = branch_cnt_q;
    assign bus.mispredict_count_o  = mispred_cnt_q;

endmodule

// File: tb/tb_mor1kx_branch_resolver.sv
// Scoreboard bench for the branch resolver: directed scenarios then random traffic, all
// checked against a queue-based reference model of the branch rules.
module tb_mor1kx_branch_resolver;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 2;
    localparam int unsigned CW = 4;
    localparam int          MaxCnt = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mor1kx_branch_resolver_if #(.OPTION_OPERAND_WIDTH(W), .CNT_WIDTH(CW)) bus ();

    mor1kx_branch_resolver #(
        .OPTION_OPERAND_WIDTH(W),
        .PRED_DEPTH(D),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        bit         bf;
        bit         flag;
        logic [W-1:0] tgt;
        logic [W-1:0] ft;
    } ent_t;
    typedef struct {
        int bc;
        int mc;
    } cnt_t;

    // Reference model state
    ent_t         m_q[$];
    bit           m_redirect = 1'b0;
    bit           m_rv = 1'b0;
    logic [W-1:0] m_rpc = '0;
    int           m_bc = 0;
    int           m_mc = 0;

    // Scoreboard
    logic [W-1:0] exp_mis_q[$];
    cnt_t         exp_cnt_q[$];
    bit           exp_ready_cur = 1'b1;
    bit           exp_rv_cur = 1'b0;
    logic [W-1:0] exp_rpc_cur = '0;
    bit           mon_en = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    // Stimulus for the next cycle
    bit           s_pv, s_bf, s_pflag, s_rv, s_flag, s_flush, s_rready, s_clr;
    logic [W-1:0] s_tgt, s_ft;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stim();
        s_pv = 0; s_bf = 0; s_pflag = 0; s_rv = 0; s_flag = 0;
        s_flush = 0; s_rready = 0; s_clr = 0; s_tgt = '0; s_ft = '0;
    endtask

    // Applies one cycle of stimulus to the model and the DUT.
    task automatic tick();
        bit           push, pop, mis, tk;
        ent_t         e;
        logic [W-1:0] pc;
        int           obc, omc;
        exp_ready_cur = (m_q.size() < D) && !m_redirect;
        exp_rv_cur    = m_rv;
        exp_rpc_cur   = m_rpc;
        push = s_pv && exp_ready_cur;
        pop  = s_rv && (m_q.size() > 0) && !m_redirect;
        mis  = 0;
        pc   = '0;
        obc  = m_bc;
        omc  = m_mc;
        if (s_flush) begin
            m_q.delete();
            m_redirect = 0;
            m_rv = 0;
        end else if (m_redirect) begin
            if (s_rready) begin
                m_redirect = 0;
                m_rv = 0;
            end
        end else begin
            if (pop) begin
                e   = m_q.pop_front();
                mis = (s_flag != e.flag);
                tk  = e.bf ? s_flag : !s_flag;
                pc  = tk ? e.tgt : e.ft;
                if (m_bc < MaxCnt) m_bc++;
                if (mis && m_mc < MaxCnt) m_mc++;
            end
            if (push) m_q.push_back('{s_bf, s_pflag, s_tgt, s_ft});
            if (mis) begin
                m_q.delete();
                m_redirect = 1;
                m_rv = 1;
                m_rpc = pc;
                exp_mis_q.push_back(pc);
            end
        end
        if (s_clr) begin
            m_bc = 0;
            m_mc = 0;
        end
        if (m_bc != obc || m_mc != omc) exp_cnt_q.push_back('{m_bc, m_mc});

        bus.pred_valid_i       = s_pv;
        bus.pred_bf_i          = s_bf;
        bus.pred_flag_i        = s_pflag;
        bus.pred_target_i      = s_tgt;
        bus.pred_fallthrough_i = s_ft;
        bus.resolve_valid_i    = s_rv;
        bus.flag_i             = s_flag;
        bus.flush_i            = s_flush;
        bus.redirect_ready_i   = s_rready;
        bus.cnt_clear_i        = s_clr;
        @(posedge clk);
        #2;
        clear_stim();
    endtask

    task automatic push_br(input bit bf, input bit pflag, input logic [W-1:0] tgt,
                           input logic [W-1:0] ft);
        s_pv = 1; s_bf = bf; s_pflag = pflag; s_tgt = tgt; s_ft = ft;
        tick();
    endtask

    task automatic resolve(input bit flag, input bit rready);
        s_rv = 1; s_flag = flag; s_rready = rready;
        tick();
    endtask

    // Monitor: compares what the DUT presents against the model's expectations.
    logic [CW-1:0] prev_bc = '0;
    logic [CW-1:0] prev_mc = '0;
    cnt_t          mon_ce;
    always @(negedge clk) begin
        if (mon_en) begin
            check("pred_ready", bus.pred_ready_o, exp_ready_cur);
            check("redirect_valid", bus.redirect_valid_o, exp_rv_cur);
            if (exp_rv_cur) check("redirect_pc_hold", bus.redirect_pc_o, exp_rpc_cur);
            if (bus.branch_mispredict_o) begin
                if (exp_mis_q.size() == 0) begin
                    check("mispredict_unexpected", 1'b1, 1'b0);
                end else begin
                    check("mispredict_pc", bus.redirect_pc_o, exp_mis_q.pop_front());
                end
            end
            if (bus.branch_count_o != prev_bc || bus.mispredict_count_o != prev_mc) begin
                if (exp_cnt_q.size() == 0) begin
                    check("counter_change_unexpected", 1'b1, 1'b0);
                end else begin
                    mon_ce = exp_cnt_q.pop_front();
                    check("branch_count", bus.branch_count_o, mon_ce.bc);
                    check("mispredict_count", bus.mispredict_count_o, mon_ce.mc);
                end
                prev_bc = bus.branch_count_o;
                prev_mc = bus.mispredict_count_o;
            end
        end
    end

    initial begin
        clear_stim();
        bus.pred_valid_i = 0; bus.pred_bf_i = 0; bus.pred_flag_i = 0;
        bus.pred_target_i = '0; bus.pred_fallthrough_i = '0; bus.resolve_valid_i = 0;
        bus.flag_i = 0; bus.flush_i = 0; bus.redirect_ready_i = 0; bus.cnt_clear_i = 0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        check("reset_pred_ready", bus.pred_ready_o, 1'b1);
        check("reset_mispredict", bus.branch_mispredict_o, 1'b0);
        check("reset_redirect_valid", bus.redirect_valid_o, 1'b0);
        check("reset_redirect_pc", bus.redirect_pc_o, 32'h0);
        check("reset_branch_count", bus.branch_count_o, 4'h0);
        check("reset_mispredict_count", bus.mispredict_count_o, 4'h0);
        mon_en = 1'b1;

        // Correct prediction
        push_br(1, 1, 32'h100, 32'h208);
        resolve(1, 0);
        tick();
        check("t1_branch_count", bus.branch_count_o, 4'd1);
        check("t1_mispredict_count", bus.mispredict_count_o, 4'd0);
        check("t1_no_mispredict", bus.branch_mispredict_o, 1'b0);
        check("t1_queue_empty_ready", bus.pred_ready_o, 1'b1);

        // Mispredict, not taken, with delayed fetch acceptance
        push_br(1, 1, 32'h100, 32'h208);
        resolve(0, 0);
        check("t2_mispredict_pulse", bus.branch_mispredict_o, 1'b1);
        check("t2_redirect_pc", bus.redirect_pc_o, 32'h208);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_valid_held", bus.redirect_valid_o, 1'b1);
            check("t2_push_blocked", bus.pred_ready_o, 1'b0);
            check("t2_pulse_one_cycle", bus.branch_mispredict_o, 1'b0);
        end
        s_rready = 1;
        tick();
        check("t2_valid_dropped", bus.redirect_valid_o, 1'b0);
        check("t2_ready_back", bus.pred_ready_o, 1'b1);

        // Mispredict with a younger entry in a full queue
        push_br(0, 1, 32'h40, 32'h80);
        push_br(0, 0, 32'h44, 32'h88);
        check("t3_full_not_ready", bus.pred_ready_o, 1'b0);
        resolve(0, 0);
        check("t3_redirect_pc", bus.redirect_pc_o, 32'h40);
        s_rready = 1;
        tick();
        resolve(0, 0);
        tick();
        check("t3_younger_discarded", bus.branch_count_o, 4'd3);
        check("t3_mispredict_count", bus.mispredict_count_o, 4'd2);

        // Flush while redirecting, then flush racing a resolve
        push_br(1, 1, 32'h300, 32'h308);
        resolve(0, 0);
        tick();
        s_flush = 1; s_pv = 1;
        tick();
        check("t4_flush_redirect_valid", bus.redirect_valid_o, 1'b0);
        check("t4_flush_ready", bus.pred_ready_o, 1'b1);
        push_br(0, 1, 32'h310, 32'h318);
        s_rv = 1; s_flag = 0; s_flush = 1;
        tick();
        resolve(0, 0);
        tick();
        check("t4_counts_bc", bus.branch_count_o, 4'd4);
        check("t4_counts_mc", bus.mispredict_count_o, 4'd3);
        check("t4_no_redirect", bus.redirect_valid_o, 1'b0);

        // Wrap-around and order
        s_clr = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            push_br(i[0], i[1], 32'h1000 + 32'(i) * 32'h10, 32'h2000 + 32'(i) * 32'h10);
            resolve((i % 3) == 0, 1);
            s_rready = 1;
            tick();
        end
        check("t5_branch_count", bus.branch_count_o, 4'd6);

        // Saturation and clear priority
        s_clr = 1;
        tick();
        for (int i = 0; i < 17; i++) begin
            push_br(1, 1, 32'h500 + 32'(i) * 4, 32'h600 + 32'(i) * 4);
            resolve(0, 1);
            s_rready = 1;
            tick();
        end
        check("t6_mispredict_sat", bus.mispredict_count_o, 4'hF);
        check("t6_branch_sat", bus.branch_count_o, 4'hF);
        push_br(1, 1, 32'h700, 32'h708);
        s_rv = 1; s_flag = 1; s_clr = 1;
        tick();
        check("t6_clear_bc", bus.branch_count_o, 4'h0);
        check("t6_clear_mc", bus.mispredict_count_o, 4'h0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            s_pv     = ($urandom % 3) != 0;
            s_bf     = $urandom_range(0, 1) != 0;
            s_pflag  = $urandom_range(0, 1) != 0;
            s_tgt    = $urandom & 32'hFFFF_FFFC;
            s_ft     = $urandom & 32'hFFFF_FFFC;
            s_rv     = $urandom_range(0, 1) != 0;
            s_flag   = $urandom_range(0, 1) != 0;
            s_flush  = ($urandom % 40) == 0;
            s_rready = ($urandom % 3) != 0;
            s_clr    = ($urandom % 50) == 0;
            tick();
        end
        s_rready = 1;
        tick();
        tick();

        check("final_mispredicts_drained", 32'(exp_mis_q.size()), 32'd0);
        check("final_counts_drained", 32'(exp_cnt_q.size()), 32'd0);
        check("final_branch_count", bus.branch_count_o, m_bc);
        check("final_mispredict_count", bus.mispredict_count_o, m_mc);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
